// File: rtl/pc_sequencer.sv
// Program counter and next-PC sequencer with interrupt/exception entry, EPC capture and fetch-wait counter.
// Optional feature: define PC_SEQ_IRQ_LATCH_EN to latch irq rising edges into a pending flag.
module pc_sequencer #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter logic [WIDTH-1:0] INT_PC     = 32'h8000_0004,
    parameter logic [WIDTH-1:0] EXP_PC     = 32'h8000_0008,
    parameter int               FETCH_WAIT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [2:0]       pc_src,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] imm32,
    input  logic [25:0]      jt,
    input  logic [WIDTH-1:0] reg_target,
    input  logic             irq,
    input  logic             exc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_4,
    output logic             instr_valid,
    output logic             int_take,
    output logic             exc_take,
    output logic [WIDTH-1:0] epc
);

    localparam logic [3:0] FW = 4'(FETCH_WAIT);

    logic [3:0]              cnt;
    logic [WIDTH-1:0]        pc_q;
    logic [WIDTH-1:0]        epc_q;
    logic [WIDTH-1:0]        next_pc;
    logic [WIDTH-1:0]        norm_pc;
    logic signed [WIDTH-1:0] br_off;
    logic                    commit;
    logic                    kernel;
    logic                    pend;

    assign kernel      = pc_q[WIDTH-1];
    assign commit      = (cnt == FW) && !stall;
    assign pc          = pc_q;
    assign pc_plus_4   = pc_q + WIDTH'(4);
    assign epc         = epc_q;
    assign instr_valid = commit;
    assign br_off      = $signed(imm32) <<< 2;

`ifdef PC_SEQ_IRQ_LATCH_EN
    logic irq_d;
    logic pending_q;

    // A rising edge counts as pending in the same cycle so a pulse landing on a commit is not missed.
    assign pend = pending_q | (irq & ~irq_d);

    always_ff @(posedge clk) begin
        irq_d <= irq;
        if (reset) begin
            pending_q <= 1'b0;
        end else if (int_take) begin
            pending_q <= 1'b0;
        end else if (irq && !irq_d) begin
            pending_q <= 1'b1;
        end
    end
`else
    assign pend = irq;
`endif

    assign exc_take = commit & exc;
    assign int_take = commit & pend & ~kernel & ~exc;

    always_comb begin
        norm_pc = pc_plus_4;
        case (pc_src)
            3'd0:    norm_pc = pc_plus_4;
            3'd1:    norm_pc = branch_taken ? (pc_plus_4 + $unsigned(br_off)) : pc_plus_4;
            3'd2:    norm_pc = {pc_plus_4[WIDTH-1:28], jt, 2'b00};
            3'd3:    norm_pc = reg_target;
            3'd4:    norm_pc = INT_PC;
            default: norm_pc = EXP_PC;
        endcase
        // User code can only reach kernel space through the vectors.
        if (!kernel && !pc_src[2]) begin
            norm_pc[WIDTH-1] = 1'b0;
        end
        if (exc_take) begin
            next_pc = EXP_PC;
        end else if (int_take) begin
            next_pc = INT_PC;
        end else begin
            next_pc = norm_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            cnt   <= '0;
            epc_q <= '0;
        end else if (commit) begin
            cnt  <= '0;
            pc_q <= next_pc;
            if (exc_take || int_take) begin
                epc_q <= pc_q;
            end
        end else if (!stall) begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: one-cycle instance driven from a vector table, two-wait instance by hand sequences.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  pc_src;
    logic        branch_taken;
    logic [31:0] imm32;
    logic [25:0] jt;
    logic [31:0] reg_target;
    logic        irq;
    logic        exc;

    logic [31:0] pc0, p40, epc0, pc2, p42, epc2;
    logic        vld0, it0, et0, vld2, it2, et2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.WIDTH(32), .FETCH_WAIT(0)) u0 (
        .clk(clk), .reset(reset), .stall(stall), .pc_src(pc_src),
        .branch_taken(branch_taken), .imm32(imm32), .jt(jt), .reg_target(reg_target),
        .irq(irq), .exc(exc), .pc(pc0), .pc_plus_4(p40), .instr_valid(vld0),
        .int_take(it0), .exc_take(et0), .epc(epc0)
    );

    pc_sequencer #(.WIDTH(32), .FETCH_WAIT(2)) u2 (
        .clk(clk), .reset(reset), .stall(stall), .pc_src(pc_src),
        .branch_taken(branch_taken), .imm32(imm32), .jt(jt), .reg_target(reg_target),
        .irq(irq), .exc(exc), .pc(pc2), .pc_plus_4(p42), .instr_valid(vld2),
        .int_take(it2), .exc_take(et2), .epc(epc2)
    );

    typedef struct {
        logic        stall;
        logic [2:0]  src;
        logic        tk;
        logic [31:0] imm;
        logic [25:0] jt;
        logic [31:0] rt;
        logic        irq;
        logic        exc;
        logic [31:0] pc;
        logic        vld;
        logic        it;
        logic        et;
        logic [31:0] npc;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic st, logic [2:0] src, logic tk, logic [31:0] imm,
                                logic [25:0] j, logic [31:0] rt, logic iq, logic ex,
                                logic [31:0] p, logic v, logic it, logic et,
                                logic [31:0] np, logic [31:0] ep);
        vec_t r;
        r.stall = st; r.src = src; r.tk = tk; r.imm = imm; r.jt = j; r.rt = rt;
        r.irq = iq; r.exc = ex; r.pc = p; r.vld = v; r.it = it; r.et = et;
        r.npc = np; r.epc = ep;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [2:0] src, input logic tk,
                         input logic [31:0] imm, input logic [25:0] j,
                         input logic [31:0] rt, input logic iq, input logic ex);
        stall = st; pc_src = src; branch_taken = tk; imm32 = imm;
        jt = j; reg_target = rt; irq = iq; exc = ex;
    endtask

    task automatic do_reset();
        drive(1'b0, 3'd0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Drives one instruction through u2 (three cycles) and checks hold, commit slot and new pc.
    task automatic fw2_instr(input string name, input logic [2:0] src, input logic tk,
                             input logic [31:0] imm, input logic [31:0] rt,
                             input logic [31:0] cur, input logic [31:0] nxt);
        drive(1'b0, src, tk, imm, 26'h0, rt, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk({name, "_pc_hold"}, pc2, cur);
            chk({name, "_vld"}, 32'(vld2), (k == 2) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        chk({name, "_pc_next"}, pc2, nxt);
    endtask

    logic [31:0] e19_pc, e19_epc, e20_epc;
    logic        e19_it;

    initial begin
`ifdef PC_SEQ_IRQ_LATCH_EN
        e19_it = 1'b1; e19_pc = 32'h8000_0004; e19_epc = 32'h0000_0200; e20_epc = 32'h8000_0004;
`else
        e19_it = 1'b0; e19_pc = 32'h0000_0204; e19_epc = 32'h0000_0300; e20_epc = 32'h0000_0204;
`endif
        //          st  src   tk  imm           jt           rt            irq exc  pc            v  it      et  npc           epc
        tbl.push_back(mk(0, 3'd0, 0, 32'h0,        26'h0,       32'h0,        0, 0, 32'h0000_0000, 1, 0,      0, 32'h0000_0004, 32'h0));
        tbl.push_back(mk(0, 3'd0, 0, 32'h0,        26'h0,       32'h0,        0, 0, 32'h0000_0004, 1, 0,      0, 32'h0000_0008, 32'h0));
        tbl.push_back(mk(0, 3'd0, 0, 32'h0,        26'h0,       32'h0,        0, 0, 32'h0000_0008, 1, 0,      0, 32'h0000_000C, 32'h0));
        tbl.push_back(mk(0, 3'd2, 0, 32'h0,        26'h0000040, 32'h0,        0, 0, 32'h0000_000C, 1, 0,      0, 32'h0000_0100, 32'h0));
        tbl.push_back(mk(0, 3'd0, 0, 32'h0,        26'h0,       32'h0,        1, 0, 32'h0000_0100, 1, 1,      0, 32'h8000_0004, 32'h100));
        tbl.push_back(mk(0, 3'd3, 0, 32'h0,        26'h0,       32'h100,      0, 0, 32'h8000_0004, 1, 0,      0, 32'h0000_0100, 32'h100));
        tbl.push_back(mk(0, 3'd1, 1, 32'hFFFF_FFFE,26'h0,       32'h0,        0, 0, 32'h0000_0100, 1, 0,      0, 32'h0000_00FC, 32'h100));
        tbl.push_back(mk(0, 3'd3, 0, 32'h0,        26'h0,       32'h9000_0000,0, 0, 32'h0000_00FC, 1, 0,      0, 32'h1000_0000, 32'h100));
        tbl.push_back(mk(0, 3'd2, 0, 32'h0,        26'h3FFFFFF, 32'h0,        0, 0, 32'h1000_0000, 1, 0,      0, 32'h1FFF_FFFC, 32'h100));
        tbl.push_back(mk(0, 3'd0, 0, 32'h0,        26'h0,       32'h0,        0, 0, 32'h1FFF_FFFC, 1, 0,      0, 32'h2000_0000, 32'h100));
        tbl.push_back(mk(0, 3'd6, 0, 32'h0,        26'h0,       32'h0,        0, 0, 32'h2000_0000, 1, 0,      0, 32'h8000_0008, 32'h100));
        tbl.push_back(mk(0, 3'd3, 0, 32'h0,        26'h0,       32'h300,      0, 0, 32'h8000_0008, 1, 0,      0, 32'h0000_0300, 32'h100));
        tbl.push_back(mk(0, 3'd0, 0, 32'h0,        26'h0,       32'h0,        1, 1, 32'h0000_0300, 1, 0,      1, 32'h8000_0008, 32'h300));
        tbl.push_back(mk(1, 3'd0, 0, 32'h0,        26'h0,       32'h0,        1, 1, 32'h8000_0008, 0, 0,      0, 32'h8000_0008, 32'h300));
        tbl.push_back(mk(0, 3'd0, 0, 32'h0,        26'h0,       32'h0,        1, 0, 32'h8000_0008, 1, 0,      0, 32'h8000_000C, 32'h300));
        tbl.push_back(mk(0, 3'd0, 0, 32'h0,        26'h0,       32'h0,        0, 0, 32'h8000_000C, 1, 0,      0, 32'h8000_0010, 32'h300));
        tbl.push_back(mk(0, 3'd0, 0, 32'h0,        26'h0,       32'h0,        1, 0, 32'h8000_0010, 1, 0,      0, 32'h8000_0014, 32'h300));
        tbl.push_back(mk(0, 3'd3, 0, 32'h0,        26'h0,       32'h200,      0, 0, 32'h8000_0014, 1, 0,      0, 32'h0000_0200, 32'h300));
        tbl.push_back(mk(0, 3'd0, 0, 32'h0,        26'h0,       32'h0,        0, 0, 32'h0000_0200, 1, e19_it, 0, e19_pc,        e19_epc));
        tbl.push_back(mk(0, 3'd0, 0, 32'h0,        26'h0,       32'h0,        0, 1, e19_pc,        1, 0,      1, 32'h8000_0008, e20_epc));
        tbl.push_back(mk(0, 3'd3, 0, 32'h0,        26'h0,       32'hFFFF_FFFC,0, 0, 32'h8000_0008, 1, 0,      0, 32'hFFFF_FFFC, e20_epc));
        tbl.push_back(mk(0, 3'd0, 0, 32'h0,        26'h0,       32'h0,        0, 0, 32'hFFFF_FFFC, 1, 0,      0, 32'h0000_0000, e20_epc));
        tbl.push_back(mk(0, 3'd1, 0, 32'h5,        26'h0,       32'h0,        0, 0, 32'h0000_0000, 1, 0,      0, 32'h0000_0004, e20_epc));

        reset = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_pc0", pc0, 32'h0);
        chk("rst_p4_0", p40, 32'h4);
        chk("rst_epc0", epc0, 32'h0);
        chk("rst_vld0", 32'(vld0), 32'd1);
        chk("rst_take0", {30'h0, it0, et0}, 32'h0);
        chk("rst_pc2", pc2, 32'h0);
        chk("rst_vld2", 32'(vld2), 32'd0);

        // Table phase on the single-cycle instance.
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].stall, tbl[i].src, tbl[i].tk, tbl[i].imm, tbl[i].jt, tbl[i].rt,
                  tbl[i].irq, tbl[i].exc);
            @(negedge clk);
            chk($sformatf("v%0d_pc", i), pc0, tbl[i].pc);
            chk($sformatf("v%0d_p4", i), p40, tbl[i].pc + 32'd4);
            chk($sformatf("v%0d_vld", i), 32'(vld0), 32'(tbl[i].vld));
            chk($sformatf("v%0d_int", i), 32'(it0), 32'(tbl[i].it));
            chk($sformatf("v%0d_exc", i), 32'(et0), 32'(tbl[i].et));
            @(posedge clk); #1;
            chk($sformatf("v%0d_npc", i), pc0, tbl[i].npc);
            chk($sformatf("v%0d_epc", i), epc0, tbl[i].epc);
        end

        // Fetch-wait instance: branch taken/not taken with the PC held between commits.
        do_reset();
        fw2_instr("fw_jr40",  3'd3, 1'b0, 32'h0,         32'h40, 32'h0,  32'h40);
        fw2_instr("fw_brtk",  3'd1, 1'b1, 32'hFFFF_FFFE, 32'h0,  32'h40, 32'h3C);
        fw2_instr("fw_jr40b", 3'd3, 1'b0, 32'h0,         32'h40, 32'h3C, 32'h40);
        fw2_instr("fw_brnt",  3'd1, 1'b0, 32'hFFFF_FFFE, 32'h0,  32'h40, 32'h44);

        // Stall for five cycles mid-wait with an irq pulse, then reset mid-wait.
        do_reset();
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 3'd0, 1'b0, 32'h0, 26'h0, 32'h0, (k == 1), 1'b0);
            @(negedge clk);
            chk($sformatf("st%0d_pc", k), pc2, 32'h0);
            chk($sformatf("st%0d_vld", k), 32'(vld2), 32'd0);
            @(posedge clk); #1;
        end
        drive(1'b0, 3'd0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rw%0d_pc", k), pc2, 32'h0);
            chk($sformatf("rw%0d_vld", k), 32'(vld2), (k == 2) ? 32'd1 : 32'd0);
            chk($sformatf("rw%0d_int", k), 32'(it2), 32'd0);
            @(posedge clk); #1;
        end
        chk("rw_pc_next", pc2, 32'h4);
        chk("rw_epc", epc2, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
